// File: rtl/arbitro_display_7seg_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the two-requester 7-segment display arbiter.
//   estado_t       : arbiter state (IDLE, GNT_A, GNT_B)
//   solicitante_t  : requester id, used to remember who was served last
//   IDLE_PATTERN_DEF : default nibbles shown while nobody owns the display
//   DIGx_LSB / DIG_ANCHO : bit position and width of each digit in a 16-bit word
// -----------------------------------------------------------------------------
package display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } estado_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } solicitante_t;

   localparam logic [15:0] IDLE_PATTERN_DEF = 16'h0000;

   localparam int DIG_ANCHO = 4;
   localparam int DIG0_LSB  = 0;
   localparam int DIG1_LSB  = 4;
   localparam int DIG2_LSB  = 8;
   localparam int DIG3_LSB  = 12;

endpackage

// File: rtl/arbitro_display_7seg_if.sv
// -----------------------------------------------------------------------------
// arbitro_display_7seg_if
// Bundles the requester handshakes and the digit bus of the display arbiter.
//   i_Req_A/B, i_Datos_A/B : requester level requests and 16-bit digit words
//   o_Gnt_A/B              : ownership flags back to the requesters
//   o_Datos_0..3           : digits towards the display controller
//   o_Retencion            : minimum-hold window still running
// modport master : requester side (drives requests, observes grants/digits)
// modport slave  : arbiter side
// -----------------------------------------------------------------------------
interface arbitro_display_7seg_if;

   logic        i_Req_A;
   logic [15:0] i_Datos_A;
   logic        i_Req_B;
   logic [15:0] i_Datos_B;
   logic        o_Gnt_A;
   logic        o_Gnt_B;
   logic [3:0]  o_Datos_0;
   logic [3:0]  o_Datos_1;
   logic [3:0]  o_Datos_2;
   logic [3:0]  o_Datos_3;
   logic        o_Retencion;

   modport master (
      output i_Req_A, i_Datos_A, i_Req_B, i_Datos_B,
      input  o_Gnt_A, o_Gnt_B, o_Datos_0, o_Datos_1, o_Datos_2, o_Datos_3,
             o_Retencion
   );

   modport slave (
      input  i_Req_A, i_Datos_A, i_Req_B, i_Datos_B,
      output o_Gnt_A, o_Gnt_B, o_Datos_0, o_Datos_1, o_Datos_2, o_Datos_3,
             o_Retencion
   );

endinterface

// File: rtl/arbitro_display_7seg_contador.sv
// -----------------------------------------------------------------------------
// contador_retencion
// Loadable, saturating down-counter that times the minimum hold of a grant.
//   i_Reloj  : clock
//   i_Reset  : asynchronous active-high reset (count cleared)
//   i_Cargar : load HOLD_CYCLES-1 on the next edge
//   o_Cero   : registered flag, high while the count is zero
// -----------------------------------------------------------------------------
module contador_retencion #(
   parameter int HOLD_CYCLES = 12_000_000
) (
   input  logic i_Reloj,
   input  logic i_Reset,
   input  logic i_Cargar,
   output logic o_Cero
);

   localparam int               ANCHO = $clog2(HOLD_CYCLES + 1);
   localparam logic [ANCHO-1:0] CARGA = ANCHO'(HOLD_CYCLES - 1);
   localparam logic [ANCHO-1:0] UNO   = ANCHO'(1);

   logic [ANCHO-1:0] r_Cuenta;
   logic             r_Cero;

   // Count register plus a zero flag kept in step so o_Cero comes straight from a flop.
   always_ff @(posedge i_Reloj or posedge i_Reset) begin
      if (i_Reset) begin
         r_Cuenta <= '0;
         r_Cero   <= 1'b1;
      end else if (i_Cargar) begin
         r_Cuenta <= CARGA;
         r_Cero   <= (CARGA == '0);
      end else if (r_Cuenta != '0) begin
         r_Cuenta <= r_Cuenta - UNO;
         r_Cero   <= (r_Cuenta == UNO);
      end else begin
         r_Cuenta <= r_Cuenta;
         r_Cero   <= 1'b1;
      end
   end

   assign o_Cero = r_Cero;

endmodule

// File: rtl/arbitro_display_7seg.sv
// -----------------------------------------------------------------------------
// arbitro_display_7seg
// Round-robin arbiter sharing one 4-digit 7-segment controller between A and B.
//   i_Reloj : clock (rising edge)
//   i_Reset : asynchronous active-high reset
//   bus     : slave side of arbitro_display_7seg_if (requests, grants, digits,
//             hold-window flag)
// A grant is held at least HOLD_CYCLES cycles unless its owner drops the
// request; with no grant the digits show IDLE_PATTERN.
// -----------------------------------------------------------------------------
module arbitro_display_7seg
   import display_pkg::*;
#(
   parameter int          HOLD_CYCLES  = 12_000_000,
   parameter logic [15:0] IDLE_PATTERN = IDLE_PATTERN_DEF
) (
   input  logic                 i_Reloj,
   input  logic                 i_Reset,
   arbitro_display_7seg_if.slave bus
);

   estado_t      r_Estado;
   estado_t      w_Sig_Estado;
   solicitante_t r_Ultimo;
   logic         r_Gnt_A;
   logic         r_Gnt_B;
   logic [3:0]   r_Datos_0;
   logic [3:0]   r_Datos_1;
   logic [3:0]   r_Datos_2;
   logic [3:0]   r_Datos_3;
   logic [15:0]  w_Fuente;
   logic         w_Cargar;
   logic         w_Cero;

   contador_retencion #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_contador (
      .i_Reloj  (i_Reloj),
      .i_Reset  (i_Reset),
      .i_Cargar (w_Cargar),
      .o_Cero   (w_Cero)
   );

   // Next-state decision; an owner dropping its request always wins over the hold.
   always_comb begin
      w_Sig_Estado = r_Estado;
      case (r_Estado)
         IDLE: begin
            if (bus.i_Req_A && bus.i_Req_B) begin
               w_Sig_Estado = (r_Ultimo == REQ_B) ? GNT_A : GNT_B;
            end else if (bus.i_Req_A) begin
               w_Sig_Estado = GNT_A;
            end else if (bus.i_Req_B) begin
               w_Sig_Estado = GNT_B;
            end else begin
               w_Sig_Estado = IDLE;
            end
         end
         GNT_A: begin
            if (!bus.i_Req_A) begin
               w_Sig_Estado = bus.i_Req_B ? GNT_B : IDLE;
            end else if (w_Cero && bus.i_Req_B) begin
               w_Sig_Estado = GNT_B;
            end else begin
               w_Sig_Estado = GNT_A;
            end
         end
         GNT_B: begin
            if (!bus.i_Req_B) begin
               w_Sig_Estado = bus.i_Req_A ? GNT_A : IDLE;
            end else if (w_Cero && bus.i_Req_A) begin
               w_Sig_Estado = GNT_A;
            end else begin
               w_Sig_Estado = GNT_B;
            end
         end
         default: begin
            w_Sig_Estado = IDLE;
         end
      endcase
   end

   // Entering any grant (from IDLE or from the other owner) restarts the hold window.
   always_comb begin
      w_Cargar = (w_Sig_Estado != r_Estado) && (w_Sig_Estado != IDLE);
   end

   // Digit source follows the next state so data switches on the same edge as the grant.
   always_comb begin
      w_Fuente = IDLE_PATTERN;
      case (w_Sig_Estado)
         GNT_A:   w_Fuente = bus.i_Datos_A;
         GNT_B:   w_Fuente = bus.i_Datos_B;
         default: w_Fuente = IDLE_PATTERN;
      endcase
   end

   // State, grants, digits and last-served register.
   always_ff @(posedge i_Reloj or posedge i_Reset) begin
      if (i_Reset) begin
         r_Estado  <= IDLE;
         r_Ultimo  <= REQ_B;
         r_Gnt_A   <= 1'b0;
         r_Gnt_B   <= 1'b0;
         r_Datos_0 <= IDLE_PATTERN[DIG0_LSB +: DIG_ANCHO];
         r_Datos_1 <= IDLE_PATTERN[DIG1_LSB +: DIG_ANCHO];
         r_Datos_2 <= IDLE_PATTERN[DIG2_LSB +: DIG_ANCHO];
         r_Datos_3 <= IDLE_PATTERN[DIG3_LSB +: DIG_ANCHO];
      end else begin
         r_Estado  <= w_Sig_Estado;
         r_Gnt_A   <= (w_Sig_Estado == GNT_A);
         r_Gnt_B   <= (w_Sig_Estado == GNT_B);
         r_Datos_0 <= w_Fuente[DIG0_LSB +: DIG_ANCHO];
         r_Datos_1 <= w_Fuente[DIG1_LSB +: DIG_ANCHO];
         r_Datos_2 <= w_Fuente[DIG2_LSB +: DIG_ANCHO];
         r_Datos_3 <= w_Fuente[DIG3_LSB +: DIG_ANCHO];
         if (w_Cargar) begin
            r_Ultimo <= (w_Sig_Estado == GNT_A) ? REQ_A : REQ_B;
         end else begin
            r_Ultimo <= r_Ultimo;
         end
      end
   end

   assign bus.o_Gnt_A     = r_Gnt_A;
   assign bus.o_Gnt_B     = r_Gnt_B;
   assign bus.o_Datos_0   = r_Datos_0;
   assign bus.o_Datos_1   = r_Datos_1;
   assign bus.o_Datos_2   = r_Datos_2;
   assign bus.o_Datos_3   = r_Datos_3;
   // Zero flag is a flop, so the inversion is glitch-free.
   assign bus.o_Retencion = ~w_Cero;

endmodule

// File: tb/tb_arbitro_display_7seg.sv
// -----------------------------------------------------------------------------
// tb_arbitro_display_7seg
// Self-checking bench: hand-derived vector table, directed corner sequences and
// a randomized phase compared against a behavioural model of the arbiter.
// -----------------------------------------------------------------------------
module tb_arbitro_display_7seg;

   localparam int          HOLD = 4;
   localparam logic [15:0] IDLE = 16'hFFFF;

   logic clk;
   logic rst;

   arbitro_display_7seg_if bus ();

   arbitro_display_7seg #(
      .HOLD_CYCLES  (HOLD),
      .IDLE_PATTERN (IDLE)
   ) dut (
      .i_Reloj (clk),
      .i_Reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Behavioural model: owner 0 = nobody, 1 = A, 2 = B; rem = hold cycles left.
   int          m_owner;
   int          m_last;
   int          m_rem;
   logic [15:0] m_dat;

   typedef struct {
      bit          rst;
      bit          ra;
      bit          rb;
      logic [15:0] da;
      logic [15:0] db;
      bit          ga;
      bit          gb;
      logic [15:0] d;
      bit          ret;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input bit r, input bit ra, input bit rb,
                               input logic [15:0] da, input logic [15:0] db,
                               input bit ga, input bit gb,
                               input logic [15:0] d, input bit ret);
      vec_t v;
      v.rst = r; v.ra = ra; v.rb = rb; v.da = da; v.db = db;
      v.ga = ga; v.gb = gb; v.d = d; v.ret = ret;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = 0;
      m_last  = 2;
      m_rem   = 0;
      m_dat   = IDLE;
   endtask

   task automatic model_step(input bit ra, input bit rb,
                             input logic [15:0] da, input logic [15:0] db);
      int nxt;
      bit own_req;
      bit oth_req;
      nxt = m_owner;
      if (m_owner == 0) begin
         if (ra && rb)  nxt = (m_last == 2) ? 1 : 2;
         else if (ra)   nxt = 1;
         else if (rb)   nxt = 2;
         else           nxt = 0;
      end else begin
         own_req = (m_owner == 1) ? ra : rb;
         oth_req = (m_owner == 1) ? rb : ra;
         if (!own_req)                   nxt = oth_req ? 3 - m_owner : 0;
         else if (m_rem == 0 && oth_req) nxt = 3 - m_owner;
         else                            nxt = m_owner;
      end
      if (nxt != 0 && nxt != m_owner) begin
         m_rem  = HOLD - 1;
         m_last = nxt;
      end else if (m_rem > 0) begin
         m_rem = m_rem - 1;
      end
      m_owner = nxt;
      m_dat   = (nxt == 1) ? da : (nxt == 2) ? db : IDLE;
   endtask

   function automatic logic [15:0] dut_digits();
      return {bus.o_Datos_3, bus.o_Datos_2, bus.o_Datos_1, bus.o_Datos_0};
   endfunction

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic tick();
      @(posedge clk);
      model_step(bus.i_Req_A, bus.i_Req_B, bus.i_Datos_A, bus.i_Datos_B);
      #1;
      chk("model_gnt", {14'b0, bus.o_Gnt_A, bus.o_Gnt_B},
          {14'b0, (m_owner == 1), (m_owner == 2)});
      chk("model_digits", dut_digits(), m_dat);
      chk("model_ret", {15'b0, bus.o_Retencion}, {15'b0, (m_rem != 0)});
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic set_in(input bit ra, input bit rb,
                         input logic [15:0] da, input logic [15:0] db);
      bus.i_Req_A   = ra;
      bus.i_Req_B   = rb;
      bus.i_Datos_A = da;
      bus.i_Datos_B = db;
   endtask

   initial begin
      int ret_cnt;
      int a_cyc;
      rst = 1'b1;
      set_in(1'b0, 1'b0, 16'h0000, 16'h0000);
      model_reset();
      reset_pulse();

      // Reset values held with no requests.
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_gnt", {14'b0, bus.o_Gnt_A, bus.o_Gnt_B}, 16'h0000);
         chk("idle_digits", dut_digits(), 16'hFFFF);
         chk("idle_ret", {15'b0, bus.o_Retencion}, 16'h0000);
      end

      // Single owner, then contention from reset (expected values derived by hand).
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 16'h9876, 16'h0000, 1'b1, 1'b0, 16'h9876, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h9876, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0));
      tbl.push_back(mk(1'b1, 1'b1, 1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b0, 16'h1234, 1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b0, 16'h1234, 1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b0, 16'h1234, 1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b0, 16'h1234, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b1, 16'hABCD, 1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b1, 16'hABCD, 1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b1, 16'hABCD, 1'b1));
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b1, 16'hABCD, 1'b0));
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b0, 16'h1234, 1'b1));

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) reset_pulse();
         set_in(tbl[i].ra, tbl[i].rb, tbl[i].da, tbl[i].db);
         tick();
         chk($sformatf("tbl%0d_gnt", i), {14'b0, bus.o_Gnt_A, bus.o_Gnt_B},
             {14'b0, tbl[i].ga, tbl[i].gb});
         chk($sformatf("tbl%0d_digits", i), dut_digits(), tbl[i].d);
         chk($sformatf("tbl%0d_ret", i), {15'b0, bus.o_Retencion}, {15'b0, tbl[i].ret});
      end

      // Hold enforcement: B arrives one cycle into A's grant.
      set_in(1'b0, 1'b0, 16'h1111, 16'h2222);
      reset_pulse();
      set_in(1'b1, 1'b0, 16'h1111, 16'h2222);
      tick();
      ret_cnt = bus.o_Retencion ? 1 : 0;
      a_cyc   = bus.o_Gnt_A ? 1 : 0;
      set_in(1'b1, 1'b1, 16'h1111, 16'h2222);
      for (int k = 0; k < 20 && !bus.o_Gnt_B; k++) begin
         tick();
         if (!bus.o_Gnt_B) begin
            if (bus.o_Retencion) ret_cnt++;
            if (bus.o_Gnt_A) a_cyc++;
         end
      end
      chk("hold_switch_to_b", {15'b0, bus.o_Gnt_B}, 16'h0001);
      chk("hold_ret_cycles", 16'(ret_cnt), 16'd3);
      chk("hold_a_cycles", 16'(a_cyc), 16'd4);
      chk("hold_b_digits", dut_digits(), 16'h2222);

      // Early release: A drops while the hold is still running and B waits.
      reset_pulse();
      set_in(1'b1, 1'b1, 16'h3333, 16'h4444);
      tick();
      chk("early_a_first", {14'b0, bus.o_Gnt_A, bus.o_Gnt_B}, 16'h0002);
      set_in(1'b0, 1'b1, 16'h3333, 16'h4444);
      tick();
      chk("early_b_gnt", {14'b0, bus.o_Gnt_A, bus.o_Gnt_B}, 16'h0001);
      chk("early_b_ret", {15'b0, bus.o_Retencion}, 16'h0001);
      tick();
      chk("early_b_ret_reloaded", {15'b0, bus.o_Retencion}, 16'h0001);

      // Asynchronous reset between clock edges while B owns the display.
      reset_pulse();
      set_in(1'b0, 1'b1, 16'h5555, 16'hABCD);
      tick();
      chk("areset_pre_gnt_b", {15'b0, bus.o_Gnt_B}, 16'h0001);
      #3;
      rst = 1'b1;
      #1;
      chk("areset_gnt", {14'b0, bus.o_Gnt_A, bus.o_Gnt_B}, 16'h0000);
      chk("areset_digits", dut_digits(), 16'hFFFF);
      chk("areset_ret", {15'b0, bus.o_Retencion}, 16'h0000);
      model_reset();
      set_in(1'b1, 1'b1, 16'h5555, 16'hABCD);
      #2;
      rst = 1'b0;
      tick();
      chk("areset_a_first", {14'b0, bus.o_Gnt_A, bus.o_Gnt_B}, 16'h0002);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic ra;
         logic rb;
         ra = bus.i_Req_A;
         rb = bus.i_Req_B;
         if ($urandom_range(0, 3) == 0) ra = ~ra;
         if ($urandom_range(0, 4) == 0) rb = ~rb;
         set_in(ra, rb, 16'($urandom), 16'($urandom));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
